// File: rtl/game_score_ctrl.sv
// game_score_ctrl: round-robin add-points arbiter feeding a saturating 3-digit BCD score.
`default_nettype none

module game_score_ctrl #(
  parameter int VAL_W = 4
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  input  logic               i_Clr,
  input  logic [3:0]         i_Req,
  input  logic [4*VAL_W-1:0] i_Val,
  output logic [3:0]         o_Ack,
  output logic [3:0]         o_Score0,
  output logic [3:0]         o_Score1,
  output logic [3:0]         o_Score2,
  output logic               o_Busy,
  output logic               o_Sat
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [3:0]         units_q, tens_q, hund_q;
  logic [VAL_W-1:0]   cnt_q;
  logic [1:0]         idx_q, ptr_q;
  logic [3:0]         ack_q;

  logic               grant_found;
  logic [1:0]         grant_idx;
  logic [VAL_W-1:0]   grant_val;
  logic [3:0]         units_d, tens_d, hund_d;
  logic               at_max;

  // Search starts one past the last granted requester and wraps mod 4.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      if (!grant_found && i_Req[ptr_q + 2'(k)]) begin
        grant_found = 1'b1;
        grant_idx   = ptr_q + 2'(k);
      end
    end
    grant_val = '0;
    for (int k = 0; k < 4; k++) begin
      if (grant_idx == 2'(k)) grant_val = i_Val[k*VAL_W +: VAL_W];
    end
  end

  always_comb begin
    units_d = units_q + 4'd1;
    tens_d  = tens_q;
    hund_d  = hund_q;
    if (units_q == 4'd9) begin
      units_d = 4'd0;
      if (tens_q == 4'd9) begin
        tens_d = 4'd0;
        hund_d = hund_q + 4'd1;
      end else begin
        tens_d = tens_q + 4'd1;
      end
    end
  end

  assign at_max = (hund_q == 4'd9) && (tens_q == 4'd9) && (units_q == 4'd9);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      units_q <= 4'd0;
      tens_q  <= 4'd0;
      hund_q  <= 4'd0;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      ptr_q   <= 2'd3;
      ack_q   <= 4'd0;
    end else if (i_Clr) begin
      state_q <= IDLE;
      units_q <= 4'd0;
      tens_q  <= 4'd0;
      hund_q  <= 4'd0;
      cnt_q   <= '0;
      ack_q   <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          ack_q <= 4'd0;
          if (grant_found) begin
            idx_q <= grant_idx;
            cnt_q <= grant_val;
            if (grant_val != '0) begin
              state_q <= RUN;
            end else begin
              state_q <= DONE;
              ack_q   <= 4'b0001 << grant_idx;
            end
          end
        end
        RUN: begin
          // At 999 the remaining points are dropped instead of wrapping.
          if (at_max) begin
            state_q <= DONE;
            ack_q   <= 4'b0001 << idx_q;
          end else begin
            units_q <= units_d;
            tens_q  <= tens_d;
            hund_q  <= hund_d;
            cnt_q   <= cnt_q - VAL_W'(1);
            if (cnt_q == VAL_W'(1)) begin
              state_q <= DONE;
              ack_q   <= 4'b0001 << idx_q;
            end
          end
        end
        DONE: begin
          ack_q   <= 4'd0;
          ptr_q   <= idx_q;
          state_q <= IDLE;
        end
        default: begin
          ack_q   <= 4'd0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_Ack    = ack_q;
  assign o_Score0 = units_q;
  assign o_Score1 = tens_q;
  assign o_Score2 = hund_q;
  assign o_Busy   = (state_q != IDLE);
  assign o_Sat    = at_max;

endmodule

`default_nettype wire
